alu_req_arbiter: RTL and testbench
==================================

# alu_req_arbiter

Two-port arbiter and sequencer for the shared synchronous arithmetic unit. It accepts operation requests from two independent clients over valid/ready handshakes and grants the unit round-robin. It drives the unit's operand and opcode inputs from registers, and captures the unit's registered result, status and error flags. The captured response goes back to the winning client, tagged with its ID. It sits between the instruction/command front-ends and the single arithmetic-unit instance.

## Interface
Parameters:
- BITS, 32, operand/result width; must match the arithmetic unit.

Ports:
- i_clk  in  1  clock, all state updates on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_req0_valid / i_req1_valid  in  1  client request pending
- o_req0_ready / o_req1_ready  out  1  request accepted this cycle when valid&ready
- i_req0_arg_A, i_req0_arg_B / i_req1_arg_A, i_req1_arg_B  in  BITS  signed operands
- i_req0_op / i_req1_op  in  2  operation code (00 conversion, 01 compare, 10 set, 11 shift)
- o_alu_arg_A, o_alu_arg_B  out  BITS  registered operands to the unit
- o_alu_op  out  2  registered opcode to the unit
- i_alu_result  in  BITS  unit registered result
- i_alu_status  in  4  unit registered status {ERROR, NOT_EVEN_ZERO, ZEROS, OVERFLOW}
- i_alu_error  in  3  unit combinational errors {konw, przes, ust}
- o_rsp_valid  out  1  response available
- i_rsp_ready  in  1  consumer takes response when valid&ready
- o_rsp_id  out  1  requester that issued the operation
- o_rsp_result  out  BITS  captured result
- o_rsp_status  out  4  captured status
- o_rsp_error  out  3  captured error flags
- o_busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, EXEC, WAIT, RESP.
- IDLE:
  - Grant is combinational from the two valids and the last-grant pointer.
  - Only the granted client sees ready=1. The other ready is 0.
  - When only one client is valid, that client is granted.
  - When both are valid, the client not granted last time is granted.
  - On accept: latch arg_A/arg_B/op into the o_alu_* registers, latch the ID, update the pointer, go to EXEC.
- EXEC:
  - o_alu_* are stable at the unit's inputs.
  - The unit registers its result at the end of this cycle.
  - Go to WAIT.
- WAIT:
  - i_alu_result and i_alu_status are valid.
  - i_alu_error is still valid, because operands are held.
  - Capture all three into the o_rsp_* registers and go to RESP.
- RESP:
  - o_rsp_valid=1. o_rsp_* are held constant until i_rsp_ready=1.
  - On the handshake, go to IDLE.
  - Both readies stay 0 until the state is back in IDLE.
- o_alu_* hold their last value outside EXEC/WAIT. They are not cleared.
- Requests not granted wait. Clients must hold valid and payload stable until ready.
- Reset (asynchronous, any state):
  - FSM returns to IDLE.
  - Last-grant pointer = 1, so req0 wins the first tie.
  - Any in-flight operation is dropped with no response.
- Reset values of outputs:
  - All o_alu_*, o_rsp_*, o_rsp_valid and o_busy = 0.
  - Readies reflect the IDLE grant logic immediately after reset release.

## Timing
- Accept at edge N (cycle 0). EXEC is cycle 1. WAIT is cycle 2. o_rsp_valid rises in cycle 3.
- Request-to-response latency is 3 cycles.
- Minimum issue interval is 4 cycles, when i_rsp_ready is held high.
- Same-cycle response handshake and new request:
  - The handshake returns the FSM to IDLE.
  - The new request is accepted in the following IDLE cycle. No bypass.
- Backpressure: i_rsp_ready low stalls the FSM in RESP indefinitely. No data loss.
- Arbitration is fair: with both clients continuously valid, grants strictly alternate 0,1,0,1.

## Configuration
- ALU_ARB_FIXED_PRIO_EN:
  - Defined: req0 always wins when both are valid. The last-grant pointer is not implemented.
  - Undefined (default): round-robin as specified above.

## Test plan
- Single request: req0 op=2'b11, A=32'h0000_00F0, B=32'h4 -> o_req0_ready=1 in cycle 0; o_alu_op=11, A/B reach the unit in cycle 1; o_rsp_valid=1, o_rsp_id=0 in cycle 3; o_rsp_result/status equal the unit's output sampled in cycle 2.
- Contention: both clients valid continuously for 4 operations, rsp_ready=1 -> grant order 0,1,0,1; o_rsp_id sequence 0,1,0,1; accepts 4 cycles apart. With ALU_ARB_FIXED_PRIO_EN defined -> order 0,0,0,0.
- Backpressure: hold i_rsp_ready=0 for 10 cycles in RESP -> o_rsp_* unchanged, both readies 0, o_busy=1; ready high for 1 cycle -> IDLE the next cycle.
- Error capture: op=2'b00 with operands that make the unit raise o_error_konw -> o_rsp_error=3'b100, o_rsp_status[3]=1 in the response.
- Reset mid-operation: assert i_reset in WAIT -> all outputs 0 asynchronously, no response issued; after release with req1 valid -> req1 is accepted next cycle.
- Late requester: req1 asserts valid while req0's operation is in EXEC -> req1 is not accepted until the cycle after the req0 response handshake.

Source files
------------

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin two-client sequencer for the shared arithmetic unit; define ALU_ARB_FIXED_PRIO_EN for fixed req0 priority.
// Latency: accept -> o_rsp_valid 3 cycles, one operation in flight, best-case issue interval 4 cycles.
// Backpressure: i_rsp_ready low parks the FSM in RESP with both request readies low; nothing is dropped.
module alu_req_arbiter #(
  parameter int BITS = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_req0_valid,
  output logic            o_req0_ready,
  input  logic [BITS-1:0] i_req0_arg_A,
  input  logic [BITS-1:0] i_req0_arg_B,
  input  logic [1:0]      i_req0_op,
  input  logic            i_req1_valid,
  output logic            o_req1_ready,
  input  logic [BITS-1:0] i_req1_arg_A,
  input  logic [BITS-1:0] i_req1_arg_B,
  input  logic [1:0]      i_req1_op,
  output logic [BITS-1:0] o_alu_arg_A,
  output logic [BITS-1:0] o_alu_arg_B,
  output logic [1:0]      o_alu_op,
  input  logic [BITS-1:0] i_alu_result,
  input  logic [3:0]      i_alu_status,
  input  logic [2:0]      i_alu_error,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic            o_rsp_id,
  output logic [BITS-1:0] o_rsp_result,
  output logic [3:0]      o_rsp_status,
  output logic [2:0]      o_rsp_error,
  output logic            o_busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0] state;
  logic       grant1;
  logic       accept;
  logic       id_q;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign grant1 = i_req1_valid & ~i_req0_valid;
`else
  // last_grant remembers the previous winner; a tie goes to the other client
  logic last_grant;

  assign grant1 = i_req1_valid & (~i_req0_valid | ~last_grant);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant1;
    end
  end
`endif

  assign o_req0_ready = (state == IDLE) & i_req0_valid & ~grant1;
  assign o_req1_ready = (state == IDLE) & grant1;
  assign accept       = o_req0_ready | o_req1_ready;
  assign o_rsp_valid  = (state == RESP);
  assign o_busy       = (state != IDLE);

  // WAIT is the one cycle where registered result/status and the operand-driven errors line up
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= IDLE;
      id_q         <= 1'b0;
      o_alu_arg_A  <= '0;
      o_alu_arg_B  <= '0;
      o_alu_op     <= 2'b00;
      o_rsp_id     <= 1'b0;
      o_rsp_result <= '0;
      o_rsp_status <= 4'b0000;
      o_rsp_error  <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state       <= EXEC;
            id_q        <= grant1;
            o_alu_arg_A <= grant1 ? i_req1_arg_A : i_req0_arg_A;
            o_alu_arg_B <= grant1 ? i_req1_arg_B : i_req0_arg_B;
            o_alu_op    <= grant1 ? i_req1_op : i_req0_op;
          end
        end
        EXEC: state <= WAIT;
        WAIT: begin
          state        <= RESP;
          o_rsp_id     <= id_q;
          o_rsp_result <= i_alu_result;
          o_rsp_status <= i_alu_status;
          o_rsp_error  <= i_alu_error;
        end
        RESP: begin
          if (i_rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: stub arithmetic unit, cycle-count transaction model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_req_arbiter;
  localparam int BITS = 32;
`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic            i_clk = 1'b0;
  logic            i_reset = 1'b1;
  logic            i_req0_valid = 1'b0, i_req1_valid = 1'b0;
  logic            o_req0_ready, o_req1_ready;
  logic [BITS-1:0] i_req0_arg_A = '0, i_req0_arg_B = '0, i_req1_arg_A = '0, i_req1_arg_B = '0;
  logic [1:0]      i_req0_op = 2'b00, i_req1_op = 2'b00;
  logic [BITS-1:0] o_alu_arg_A, o_alu_arg_B;
  logic [1:0]      o_alu_op;
  logic [BITS-1:0] i_alu_result = '0;
  logic [3:0]      i_alu_status = 4'b0000;
  logic [2:0]      i_alu_error;
  logic            o_rsp_valid, o_rsp_id, o_busy;
  logic            i_rsp_ready = 1'b0;
  logic [BITS-1:0] o_rsp_result;
  logic [3:0]      o_rsp_status;
  logic [2:0]      o_rsp_error;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit hs0 = 1'b0, hs1 = 1'b0;

  alu_req_arbiter #(.BITS(BITS)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready),
    .i_req0_arg_A(i_req0_arg_A), .i_req0_arg_B(i_req0_arg_B), .i_req0_op(i_req0_op),
    .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready),
    .i_req1_arg_A(i_req1_arg_A), .i_req1_arg_B(i_req1_arg_B), .i_req1_op(i_req1_op),
    .o_alu_arg_A(o_alu_arg_A), .o_alu_arg_B(o_alu_arg_B), .o_alu_op(o_alu_op),
    .i_alu_result(i_alu_result), .i_alu_status(i_alu_status), .i_alu_error(i_alu_error),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_id(o_rsp_id),
    .o_rsp_result(o_rsp_result), .o_rsp_status(o_rsp_status), .o_rsp_error(o_rsp_error),
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Stand-in arithmetic unit: {konw, przes, ust} errors, status {ERROR, odd, zero, overflow}
  function automatic logic [2:0] f_err(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    return {op == 2'b00 && a == 32'h8000_0000, op == 2'b11 && b > 32'd31, op == 2'b10 && b[31]};
  endfunction

  function automatic logic [31:0] f_res(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    case (op)
      2'b00:   return -a;
      2'b01:   return {31'b0, $signed(a) < $signed(b)};
      2'b10:   return b;
      default: return a >> b[4:0];
    endcase
  endfunction

  function automatic logic [3:0] f_stat(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    logic [31:0] r;
    r = f_res(a, b, op);
    return {|f_err(a, b, op), r[0], r == 32'd0, 1'b0};
  endfunction

  always @(posedge i_clk) begin
    i_alu_result <= f_res(o_alu_arg_A, o_alu_arg_B, o_alu_op);
    i_alu_status <= f_stat(o_alu_arg_A, o_alu_arg_B, o_alu_op);
  end
  assign i_alu_error = f_err(o_alu_arg_A, o_alu_arg_B, o_alu_op);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: one op in flight, response valid 3 cycles after its accept cycle
  bit          m_active = 1'b0, m_last = 1'b1, m_id = 1'b0, m_g, m_r0, m_r1, m_rv;
  int          m_acc = 0;
  logic [31:0] m_a = '0, m_b = '0;
  logic [1:0]  m_op = 2'b00;

  always @(negedge i_clk) begin
    cyc++;
    hs0 = o_req0_ready & i_req0_valid;
    hs1 = o_req1_ready & i_req1_valid;
    if (i_reset) begin
      m_active = 1'b0; m_last = 1'b1;
      m_a = '0; m_b = '0; m_op = 2'b00;
    end else begin
      m_rv = m_active && (cyc >= m_acc + 3);
      if (i_req0_valid && i_req1_valid) m_g = FIXED ? 1'b0 : !m_last;
      else m_g = i_req1_valid;
      m_r0 = !m_active && i_req0_valid && !m_g;
      m_r1 = !m_active && i_req1_valid && m_g;
      chk("req0_ready", 64'(o_req0_ready), 64'(m_r0));
      chk("req1_ready", 64'(o_req1_ready), 64'(m_r1));
      chk("busy", 64'(o_busy), 64'(m_active));
      chk("rsp_valid", 64'(o_rsp_valid), 64'(m_rv));
      chk("alu_A", 64'(o_alu_arg_A), 64'(m_a));
      chk("alu_B", 64'(o_alu_arg_B), 64'(m_b));
      chk("alu_op", 64'(o_alu_op), 64'(m_op));
      if (m_rv) begin
        chk("rsp_id", 64'(o_rsp_id), 64'(m_id));
        chk("rsp_result", 64'(o_rsp_result), 64'(f_res(m_a, m_b, m_op)));
        chk("rsp_status", 64'(o_rsp_status), 64'(f_stat(m_a, m_b, m_op)));
        chk("rsp_error", 64'(o_rsp_error), 64'(f_err(m_a, m_b, m_op)));
      end
      if (!m_active && (i_req0_valid || i_req1_valid)) begin
        m_active = 1'b1; m_acc = cyc; m_last = m_g; m_id = m_g;
        m_a  = m_g ? i_req1_arg_A : i_req0_arg_A;
        m_b  = m_g ? i_req1_arg_B : i_req0_arg_B;
        m_op = m_g ? i_req1_op : i_req0_op;
      end else if (m_rv && i_rsp_ready) begin
        m_active = 1'b0;
      end
    end
  end

  task automatic tick(); @(posedge i_clk); #1; endtask
  task automatic look(); @(negedge i_clk); #1; endtask

  task automatic gen(output logic [31:0] a, output logic [31:0] b, output logic [1:0] op);
    a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
    b  = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 40));
    op = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 20; i++) begin
      if (o_rsp_valid) break;
      tick(); look();
    end
    chk("wait_rsp", 64'(o_rsp_valid), 64'(1));
  endtask

  task automatic drain();
    i_rsp_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (!o_busy) break;
      tick(); look();
    end
    chk("drain", 64'(o_busy), 64'(0));
  endtask

  task automatic do_reset();
    tick();
    i_reset = 1'b1; i_req0_valid = 1'b0; i_req1_valid = 1'b0; i_rsp_ready = 1'b0;
    look();
    tick();
    i_reset = 1'b0;
  endtask

  int acc_cyc[8];
  bit acc_id[8];
  int n;

  initial begin
    repeat (3) @(posedge i_clk);
    #1 i_reset = 1'b0;
    look();
    chk("rst_busy", 64'(o_busy), 64'(0));
    chk("rst_rsp_valid", 64'(o_rsp_valid), 64'(0));
    chk("rst_alu", 64'({o_alu_op, o_alu_arg_A}), 64'(0));
    chk("rst_rsp", 64'({o_rsp_result, o_rsp_status, o_rsp_error, o_rsp_id}), 64'(0));

    // Single request: shift 0xF0 >> 4
    tick();
    i_req0_arg_A = 32'h0000_00F0; i_req0_arg_B = 32'h4; i_req0_op = 2'b11;
    i_req0_valid = 1'b1; i_rsp_ready = 1'b1;
    look(); chk("single_ready0", 64'(o_req0_ready), 64'(1));
    tick(); i_req0_valid = 1'b0;
    look(); chk("single_alu", 64'({o_alu_op, o_alu_arg_B[7:0], o_alu_arg_A}), {22'b0, 2'b11, 8'h04, 32'h0000_00F0});
    tick(); look(); chk("single_c2_valid", 64'(o_rsp_valid), 64'(0));
    tick(); look();
    chk("single_c3_valid", 64'(o_rsp_valid), 64'(1));
    chk("single_rsp", 64'({o_rsp_id, o_rsp_result, o_rsp_status, o_rsp_error}), 64'({1'b0, 32'h0000_000F, 4'b0100, 3'b000}));
    tick(); look(); chk("single_idle", 64'(o_busy), 64'(0));

    // Backpressure, with req1 arriving while req0 is in EXEC
    tick();
    i_rsp_ready = 1'b0;
    i_req0_arg_A = 32'd5; i_req0_arg_B = 32'd9; i_req0_op = 2'b01; i_req0_valid = 1'b1;
    look(); chk("bp_ready0", 64'(o_req0_ready), 64'(1));
    tick();
    i_req0_valid = 1'b0;
    i_req1_arg_A = 32'd7; i_req1_arg_B = 32'h1234; i_req1_op = 2'b10; i_req1_valid = 1'b1;
    look(); chk("late_exec_ready1", 64'(o_req1_ready), 64'(0));
    wait_rsp();
    for (int i = 0; i < 10; i++) begin
      tick(); look();
      chk("bp_hold", 64'({o_rsp_id, o_rsp_result, o_rsp_status, o_rsp_error}), 64'({1'b0, 32'h1, 4'b0100, 3'b000}));
      chk("bp_readies", 64'({o_req0_ready, o_req1_ready, o_busy, o_rsp_valid}), 64'(4'b0011));
    end
    tick(); i_rsp_ready = 1'b1;
    look();
    tick(); i_rsp_ready = 1'b0;
    look();
    chk("bp_idle", 64'(o_busy), 64'(0));
    chk("late_ready1", 64'(o_req1_ready), 64'(1));
    tick(); i_req1_valid = 1'b0;
    drain();

    // Error capture: conversion of the most negative value
    tick();
    i_req0_arg_A = 32'h8000_0000; i_req0_arg_B = 32'd0; i_req0_op = 2'b00; i_req0_valid = 1'b1;
    look();
    tick(); i_req0_valid = 1'b0;
    look();
    wait_rsp();
    chk("err_flags", 64'(o_rsp_error), 64'(3'b100));
    chk("err_status3", 64'(o_rsp_status[3]), 64'(1));
    chk("err_result", 64'(o_rsp_result), 64'(32'h8000_0000));
    drain();

    // Reset while the operation is in WAIT
    tick();
    i_req0_arg_A = 32'd1; i_req0_arg_B = 32'd1; i_req0_op = 2'b11; i_req0_valid = 1'b1;
    look();
    tick(); i_req0_valid = 1'b0;
    look(); chk("rm_exec_busy", 64'(o_busy), 64'(1));
    @(posedge i_clk); #3;
    i_reset = 1'b1;
    #1;
    chk("rm_async_ctl", 64'({o_busy, o_rsp_valid, o_req0_ready, o_req1_ready}), 64'(0));
    chk("rm_async_alu", 64'({o_alu_op, o_alu_arg_A}), 64'(0));
    chk("rm_async_rsp", 64'({o_rsp_result, o_rsp_status, o_rsp_error, o_rsp_id}), 64'(0));
    look();
    tick();
    i_reset = 1'b0;
    i_req1_arg_A = 32'h40; i_req1_arg_B = 32'd2; i_req1_op = 2'b11; i_req1_valid = 1'b1;
    look(); chk("rm_ready1", 64'(o_req1_ready), 64'(1));
    tick(); i_req1_valid = 1'b0;
    look();
    wait_rsp();
    chk("rm_rsp_id", 64'(o_rsp_id), 64'(1));
    drain();

    // Contention from a fresh reset
    do_reset();
    i_rsp_ready = 1'b1;
    gen(i_req0_arg_A, i_req0_arg_B, i_req0_op);
    gen(i_req1_arg_A, i_req1_arg_B, i_req1_op);
    i_req0_valid = 1'b1; i_req1_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      look();
      if (o_req0_ready && n < 8) begin acc_id[n] = 1'b0; acc_cyc[n] = cyc; n++; end
      if (o_req1_ready && n < 8) begin acc_id[n] = 1'b1; acc_cyc[n] = cyc; n++; end
      tick();
      if (hs0) gen(i_req0_arg_A, i_req0_arg_B, i_req0_op);
      if (hs1) gen(i_req1_arg_A, i_req1_arg_B, i_req1_op);
    end
    i_req0_valid = 1'b0; i_req1_valid = 1'b0;
    chk("cont_count", 64'(n), 64'(4));
    for (int k = 0; k < 4 && k < n; k++) begin
      chk("cont_grant", 64'(acc_id[k]), FIXED ? 64'(0) : 64'(k % 2));
      if (k > 0) chk("cont_spacing", 64'(acc_cyc[k] - acc_cyc[k-1]), 64'(4));
    end
    look();
    drain();

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (hs0 || !i_req0_valid) begin
        i_req0_valid = ($urandom_range(0, 2) == 0);
        if (i_req0_valid) gen(i_req0_arg_A, i_req0_arg_B, i_req0_op);
      end
      if (hs1 || !i_req1_valid) begin
        i_req1_valid = ($urandom_range(0, 2) == 0);
        if (i_req1_valid) gen(i_req1_arg_A, i_req1_arg_B, i_req1_op);
      end
      i_rsp_ready = ($urandom_range(0, 3) != 0);
    end
    tick();
    if (!hs0 && i_req0_valid) begin look(); tick(); end
    i_req0_valid = 1'b0; i_req1_valid = 1'b0;
    look();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
